// File: rtl/tile_store_ctrl_pkg.sv
// Shared types, defaults and derived widths
// for the tile store controller.
package tile_store_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      WRITE = 2'd2
   } state_t;

   localparam int NBUF_DEF   = 4;
   localparam int LANES_DEF  = 4;
   localparam int ADDR_W_DEF = 32;

   function automatic int dim_w(input int nbuf, input int lanes);
      return $clog2(nbuf * lanes) + 1;
   endfunction

   function automatic int bytes_w(input int lanes);
      return $clog2(lanes * 4) + 1;
   endfunction

   function automatic int sel_w(input int nbuf);
      return (nbuf > 1) ? $clog2(nbuf) : 1;
   endfunction

   localparam int DIM_W_DEF   = dim_w(NBUF_DEF, LANES_DEF);
   localparam int BYTES_W_DEF = bytes_w(LANES_DEF);
   localparam int SEL_W_DEF   = sel_w(NBUF_DEF);

endpackage

// File: rtl/tile_store_ctrl_if.sv
// Buffer-pop and write-request bus between
// the store controller and the memory side.
interface tile_store_ctrl_if
   import tile_store_ctrl_pkg::*;
#(
   parameter int NBUF   = NBUF_DEF,
   parameter int LANES  = LANES_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);
   localparam int SEL_W   = sel_w(NBUF);
   localparam int BYTES_W = bytes_w(LANES);

   logic [NBUF-1:0]    buf_empty;
   logic [NBUF-1:0]    buf_pop;
   logic [SEL_W-1:0]   buf_sel;
   logic               wr_valid;
   logic               wr_ready;
   logic [ADDR_W-1:0]  wr_addr;
   logic [BYTES_W-1:0] wr_bytes;

   modport master (
      input  buf_empty, wr_ready,
      output buf_pop, buf_sel, wr_valid,
      output wr_addr, wr_bytes
   );

   modport slave (
      output buf_empty, wr_ready,
      input  buf_pop, buf_sel, wr_valid,
      input  wr_addr, wr_bytes
   );

endinterface

// File: rtl/store_addr_gen.sv
// Row/chunk counters and write address/size
// generation for one tile.
module store_addr_gen
   import tile_store_ctrl_pkg::*;
#(
   parameter int NBUF    = NBUF_DEF,
   parameter int LANES   = LANES_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DIM_W   = DIM_W_DEF,
   parameter int SEL_W   = SEL_W_DEF,
   parameter int BYTES_W = BYTES_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               adv,
   input  logic [ADDR_W-1:0]  tile_c_addr,
   input  logic [ADDR_W-1:0]  row_stride,
   input  logic [DIM_W-1:0]   msize,
   input  logic [DIM_W-1:0]   nsize,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [BYTES_W-1:0] wr_bytes,
   output logic [SEL_W-1:0]   k,
   output logic [SEL_W-1:0]   k_next,
   output logic               last
);
   logic [ADDR_W-1:0] row_addr;
   logic [ADDR_W-1:0] stride_q;
   logic [DIM_W-1:0]  m_q;
   logic [DIM_W-1:0]  n_q;
   logic [DIM_W-1:0]  row;
   logic [DIM_W-1:0]  nchunks;
   logic [DIM_W-1:0]  off;
   logic [DIM_W-1:0]  rem;
   logic              row_end;

   // chunk geometry and the address/size of the current write
   always_comb begin
      nchunks  = (n_q + DIM_W'(LANES - 1)) / DIM_W'(LANES);
      off      = DIM_W'(k) * DIM_W'(LANES);
      rem      = n_q - off;
      wr_bytes = (rem >= DIM_W'(LANES))
               ? BYTES_W'(LANES * 4)
               : (BYTES_W'(rem) << 2);
      wr_addr  = row_addr + (ADDR_W'(off) << 2);
      row_end  = (DIM_W'(k) == nchunks - DIM_W'(1));
      last     = row_end && (row == m_q - DIM_W'(1));
      k_next   = row_end ? '0 : k + SEL_W'(1);
   end

   // latch tile geometry on load, step counters per handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         row_addr <= '0;
         stride_q <= '0;
         m_q      <= '0;
         n_q      <= '0;
         row      <= '0;
         k        <= '0;
      end else if (load) begin
         row_addr <= tile_c_addr;
         stride_q <= row_stride;
         m_q      <= msize;
         n_q      <= nsize;
         row      <= '0;
         k        <= '0;
      end else if (adv) begin
         k <= k_next;
         if (row_end) begin
            row      <= row + DIM_W'(1);
            row_addr <= row_addr + (stride_q << 2);
         end
      end
   end

endmodule

// File: rtl/tile_store_ctrl.sv
// Streams one result tile from the column
// buffers to memory, one chunk per write.
module tile_store_ctrl
   import tile_store_ctrl_pkg::*;
#(
   parameter int NBUF   = NBUF_DEF,
   parameter int LANES  = LANES_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DIM_W  = dim_w(NBUF, LANES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] tile_c_addr,
   input  logic [ADDR_W-1:0] row_stride,
   input  logic [DIM_W-1:0]  msize,
   input  logic [DIM_W-1:0]  nsize,
   tile_store_ctrl_if.master bus,
   output logic              busy,
   output logic              done,
   output logic              err
);
   localparam int SEL_W   = sel_w(NBUF);
   localparam int BYTES_W = bytes_w(LANES);
   localparam int MAXD    = NBUF * LANES;

   state_t             state;
   state_t             state_nx;
   logic               accept;
   logic               bad;
   logic               load;
   logic               hs;
   logic               last;
   logic               done_q;
   logic               err_q;
   logic [SEL_W-1:0]   k;
   logic [SEL_W-1:0]   k_next;
   logic [ADDR_W-1:0]  gen_addr;
   logic [BYTES_W-1:0] gen_bytes;

   assign bad = (msize == '0) || (msize > DIM_W'(MAXD))
             || (nsize == '0) || (nsize > DIM_W'(MAXD));
   assign accept = start && (state == IDLE);
   assign load   = accept && !bad;
   assign hs     = (state == WRITE) && bus.wr_ready;

   store_addr_gen #(
      .NBUF    (NBUF),
      .LANES   (LANES),
      .ADDR_W  (ADDR_W),
      .DIM_W   (DIM_W),
      .SEL_W   (SEL_W),
      .BYTES_W (BYTES_W)
   ) u_gen (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .adv         (hs),
      .tile_c_addr (tile_c_addr),
      .row_stride  (row_stride),
      .msize       (msize),
      .nsize       (nsize),
      .wr_addr     (gen_addr),
      .wr_bytes    (gen_bytes),
      .k           (k),
      .k_next      (k_next),
      .last        (last)
   );

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // next state: skip WAIT whenever the needed buffer has data
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (load)
               state_nx = bus.buf_empty[0] ? WAIT : WRITE;
         end
         WAIT: begin
            if (!bus.buf_empty[k]) state_nx = WRITE;
         end
         WRITE: begin
            if (bus.wr_ready) begin
               if (last)
                  state_nx = IDLE;
               else if (bus.buf_empty[k_next])
                  state_nx = WAIT;
               else
                  state_nx = WRITE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // bus outputs: only live in WRITE, forced low under reset
   always_comb begin
      bus.wr_valid = 1'b0;
      bus.buf_pop  = '0;
      bus.buf_sel  = '0;
      bus.wr_addr  = '0;
      bus.wr_bytes = '0;
      busy         = (state != IDLE) && !rst;
      done         = done_q && !rst;
      err          = err_q && !rst;
      if ((state == WRITE) && !rst) begin
         bus.wr_valid   = 1'b1;
         bus.buf_sel    = k;
         bus.wr_addr    = gen_addr;
         bus.wr_bytes   = gen_bytes;
         bus.buf_pop[k] = bus.wr_ready;
      end
   end

   // done/err pulses, registered so done lands as busy falls
   always_ff @(posedge clk) begin
      if (rst) begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         done_q <= (accept && bad) || (hs && last);
         err_q  <= accept && bad;
      end
   end

endmodule
